pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Program-counter and fetch sequencer for the 8-bit RISC CPU. Owns the PC register and fetches
//  each instruction from memory. Drives the operands of an external Adder_8bit instance and
//  captures its total as the next PC, so increments, skips and wrap-around all use that adder.
//  Sits between the controller (decode/execute) and instruction memory.
// PARAMETERS
//  RESET_PC      8'h00  PC value loaded on rst
//  SKIP_INC      8'h02  increment applied on a taken skip (normal increment is 8'h01)
//  FETCH_TIMEOUT 15     max cycles waiting for mem_ready before fault (1..255)
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  synchronous, active-high reset
//  start      in   1  leave IDLE and begin fetching at current PC
//  mem_ready  in   1  instruction memory data valid this cycle
//  exec_done  in   1  controller finished executing the latched instruction
//  jump       in   1  with exec_done: load jump_addr into PC
//  jump_addr  in   8  jump target
//  skip_z     in   1  with exec_done: skip next instruction if zero_flag
//  zero_flag  in   1  accumulator-zero flag from datapath
//  halt_req   in   1  with exec_done: enter HALT after PC update
//  add_sum    in   8  total from Adder_8bit
//  add_a      out  8  adder operand A (always = pc)
//  add_b      out  8  adder operand B (increment select)
//  pc         out  8  current program counter / instruction address
//  mem_rd     out  1  instruction read request
//  ir_load    out  1  one-cycle strobe: controller latches memory data into IR
//  busy       out  1  high in FETCH, LATCH, EXEC and UPDATE
//  halted     out  1  high in HALT
//  fault      out  1  sticky fetch-timeout flag, cleared only by rst
// BEHAVIOUR
//  Reset (registered, next edge): state=IDLE, pc=RESET_PC, mem_rd=0, ir_load=0, fault=0,
//   timeout cnt=0, add_b=8'h00. rst overrides every other input in every state.
//  States:
//   IDLE   : outputs idle. start=1 -> FETCH.
//   FETCH  : mem_rd=1, pc held. mem_ready=1 -> LATCH, cnt cleared. Otherwise cnt++.
//            If cnt reaches FETCH_TIMEOUT without mem_ready: fault=1 -> HALT.
//            mem_ready in the same cycle as the final count wins (-> LATCH).
//   LATCH  : ir_load=1 for exactly this cycle, mem_rd=0 -> EXEC.
//   EXEC   : waits for exec_done (may take any number of cycles). On exec_done:
//            jump=1 -> pc<=jump_addr directly (adder bypassed); then -> FETCH, or HALT if halt_req.
//            otherwise add_b=(skip_z&zero_flag)?SKIP_INC:8'h01 -> UPDATE.
//            Priority: jump > skip > increment. halt_req is applied after the PC update.
//   UPDATE : pc<=add_sum -> FETCH, or HALT if halt_req was set at exec_done (registered).
//   HALT   : all strobes 0, pc frozen, halted=1. start is ignored; only rst exits.
//  add_b: drives the registered increment only during UPDATE, 8'h00 otherwise.
//   add_a=pc at all times. The adder is combinational, so add_sum is sampled in the UPDATE cycle.
//  Arithmetic: modulo 256, carry discarded. Examples: 8'hFF+1=8'h00, 8'hFE+2=8'h00, 8'hFF+2=8'h01.
//  Latency: exec_done -> next mem_rd = 2 cycles (increment/skip) or 1 cycle (jump).
//   start -> first mem_rd = 1 cycle. mem_ready -> ir_load = 1 cycle.
//  Inputs jump, skip_z, halt_req, zero_flag and jump_addr are sampled only in the exec_done cycle.
//   exec_done outside EXEC is ignored.
//  mem_ready outside FETCH is ignored.
//  Reset mid-fetch drops mem_rd on the next edge. No ir_load is issued for the aborted fetch.
// STRUCTURE
//  Shared package cpu_pkg: state enum encoding (IDLE, FETCH, LATCH, EXEC, UPDATE, HALT),
//   PC_INC=8'h01, data/address width constant 8.
//  Single module with no sub-modules. Adder_8bit is instantiated beside this block at CPU top
//   level, not inside it. The timeout counter is inline, 8 bits wide.
// TESTING
//  1 rst, start, mem_ready after 2 cycles -> mem_rd 2 cycles at pc=00, ir_load one cycle,
//    exec_done -> pc=01 after 2 cycles.
//  2 pc=8'hFE, exec_done with skip_z=1, zero_flag=1 -> pc=8'h00. Repeat at pc=8'hFF -> pc=8'h01.
//    With zero_flag=0 at pc=8'hFF -> pc=8'h00.
//  3 exec_done with jump=1, jump_addr=8'h3C, skip_z=1, zero_flag=1 -> pc=8'h3C,
//    mem_rd asserted 1 cycle later, add_b stays 00.
//  4 exec_done with halt_req=1 at pc=8'h10 -> pc=8'h11, halted=1. start pulses ignored.
//    rst -> pc=00, state IDLE.
//  5 mem_ready withheld for 15 cycles in FETCH -> fault=1, halted=1, mem_rd=0.
//    Second run with mem_ready on cycle 15 -> LATCH, no fault.
//  6 rst asserted during FETCH and during EXEC -> next edge: mem_rd=0, ir_load=0, pc=RESET_PC;
//    exec_done pulses in IDLE have no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared 8-bit CPU constants: datapath width, sequencer state encoding and the default PC step.
package cpu_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ST_W   = 3;

   typedef logic [ST_W-1:0] state_t;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_LATCH  = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_UPDATE = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;

   localparam logic [DATA_W-1:0] PC_INC = 8'h01;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter and instruction-fetch sequencer; PC increments and skips go through the
// external Adder_8bit (operands out on add_a/add_b, total back on add_sum).
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter logic [DATA_W-1:0] RESET_PC      = 8'h00,
   parameter logic [DATA_W-1:0] SKIP_INC      = 8'h02,
   parameter int unsigned       FETCH_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mem_ready,
   input  logic              exec_done,
   input  logic              jump,
   input  logic [DATA_W-1:0] jump_addr,
   input  logic              skip_z,
   input  logic              zero_flag,
   input  logic              halt_req,
   input  logic [DATA_W-1:0] add_sum,
   output logic [DATA_W-1:0] add_a,
   output logic [DATA_W-1:0] add_b,
   output logic [DATA_W-1:0] pc,
   output logic              mem_rd,
   output logic              ir_load,
   output logic              busy,
   output logic              halted,
   output logic              fault
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] add_b_q, add_b_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              halt_pend_q, halt_pend_d;
   logic              fault_q, fault_d;
   logic              mem_rd_q, mem_rd_d;
   logic              ir_load_q, ir_load_d;
   logic              busy_q, busy_d;
   logic              halted_q, halted_d;

   // State register plus registered outputs, all derived from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         add_b_q     <= '0;
         cnt_q       <= '0;
         halt_pend_q <= 1'b0;
         fault_q     <= 1'b0;
         mem_rd_q    <= 1'b0;
         ir_load_q   <= 1'b0;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         add_b_q     <= add_b_d;
         cnt_q       <= cnt_d;
         halt_pend_q <= halt_pend_d;
         fault_q     <= fault_d;
         mem_rd_q    <= mem_rd_d;
         ir_load_q   <= ir_load_d;
         busy_q      <= busy_d;
         halted_q    <= halted_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      add_b_d     = '0;
      cnt_d       = cnt_q;
      halt_pend_d = halt_pend_q;
      fault_d     = fault_q;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            // A ready arriving on the final count still wins over the timeout.
            if (mem_ready) begin
               state_d = ST_LATCH;
               cnt_d   = '0;
            end else if (cnt_q == 8'(FETCH_TIMEOUT - 1)) begin
               state_d = ST_HALT;
               fault_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_LATCH: state_d = ST_EXEC;
         ST_EXEC: begin
            if (exec_done) begin
               halt_pend_d = halt_req;
               if (jump) begin
                  pc_d    = jump_addr;
                  state_d = halt_req ? ST_HALT : ST_FETCH;
               end else begin
                  add_b_d = (skip_z && zero_flag) ? SKIP_INC : PC_INC;
                  state_d = ST_UPDATE;
               end
            end
         end
         ST_UPDATE: begin
            pc_d    = add_sum;
            state_d = halt_pend_q ? ST_HALT : ST_FETCH;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase

      mem_rd_d  = (state_d == ST_FETCH);
      ir_load_d = (state_d == ST_LATCH);
      busy_d    = (state_d == ST_FETCH) || (state_d == ST_LATCH) ||
                  (state_d == ST_EXEC)  || (state_d == ST_UPDATE);
      halted_d  = (state_d == ST_HALT);
   end

   assign add_a   = pc_q;
   assign add_b   = add_b_q;
   assign pc      = pc_q;
   assign mem_rd  = mem_rd_q;
   assign ir_load = ir_load_q;
   assign busy    = busy_q;
   assign halted  = halted_q;
   assign fault   = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected fetch/halt events and output
// snapshots; a negedge monitor pops and compares them. The Adder_8bit is modelled inline.
module tb_pc_sequencer;

   typedef struct {
      string      nm;
      logic [7:0] pc;
      logic [7:0] add_b;
      logic       mem_rd;
      logic       ir_load;
      logic       busy;
      logic       halted;
      logic       fault;
   } snap_t;

   typedef struct {
      bit         halt;
      logic [7:0] pc;
      logic       fault;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, mem_ready = 1'b0, exec_done = 1'b0, jump = 1'b0;
   logic [7:0] jump_addr = 8'h00;
   logic       skip_z = 1'b0, zero_flag = 1'b0, halt_req = 1'b0;
   logic [7:0] add_sum, add_a, add_b, pc;
   logic       mem_rd, ir_load, busy, halted, fault;

   snap_t chk_q[$];
   ev_t   ev_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   bit    done = 1'b0;
   logic  prev_rd = 1'b0, prev_halted = 1'b0, prev_irl = 1'b0;

   always #5 clk = ~clk;

   assign add_sum = 8'(add_a + add_b);

   pc_sequencer #(
      .RESET_PC     (8'h00),
      .SKIP_INC     (8'h02),
      .FETCH_TIMEOUT(15)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mem_ready (mem_ready),
      .exec_done (exec_done),
      .jump      (jump),
      .jump_addr (jump_addr),
      .skip_z    (skip_z),
      .zero_flag (zero_flag),
      .halt_req  (halt_req),
      .add_sum   (add_sum),
      .add_a     (add_a),
      .add_b     (add_b),
      .pc        (pc),
      .mem_rd    (mem_rd),
      .ir_load   (ir_load),
      .busy      (busy),
      .halted    (halted),
      .fault     (fault)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_now(input string nm, input logic [7:0] e_pc, input logic [7:0] e_addb,
                             input logic e_rd, input logic e_irl, input logic e_busy,
                             input logic e_hlt, input logic e_flt);
      snap_t s;
      s.nm = nm; s.pc = e_pc; s.add_b = e_addb; s.mem_rd = e_rd; s.ir_load = e_irl;
      s.busy = e_busy; s.halted = e_hlt; s.fault = e_flt;
      chk_q.push_back(s);
   endtask

   task automatic expect_event(input bit e_halt, input logic [7:0] e_pc, input logic e_flt);
      ev_t e;
      e.halt = e_halt; e.pc = e_pc; e.fault = e_flt;
      ev_q.push_back(e);
   endtask

   // From FETCH: memory answers at once, then LATCH -> EXEC.
   task automatic fetch_ok();
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
   endtask

   // From EXEC: one exec_done with the given controls; ends in FETCH or HALT.
   task automatic exec_op(input logic j, input logic [7:0] addr, input logic sk, input logic zf,
                          input logic hr, input logic [7:0] exp_pc);
      expect_event(hr, exp_pc, 1'b0);
      exec_done = 1'b1; jump = j; jump_addr = addr; skip_z = sk; zero_flag = zf; halt_req = hr;
      tick();
      exec_done = 1'b0; jump = 1'b0; jump_addr = 8'h00; skip_z = 1'b0; zero_flag = 1'b0;
      halt_req = 1'b0;
      if (!j) tick();
   endtask

   // Monitor: pops snapshot checks and fetch/halt events whenever the DUT presents them.
   always @(negedge clk) begin
      snap_t s;
      ev_t   e;
      while (chk_q.size() > 0) begin
         s = chk_q.pop_front();
         n_vec++;
         if ({pc, add_b, mem_rd, ir_load, busy, halted, fault} !==
             {s.pc, s.add_b, s.mem_rd, s.ir_load, s.busy, s.halted, s.fault}) begin
            n_err++;
            $display("FAIL %s: got pc=%h add_b=%h rd=%b irl=%b busy=%b hlt=%b flt=%b, want pc=%h add_b=%h rd=%b irl=%b busy=%b hlt=%b flt=%b",
                     s.nm, pc, add_b, mem_rd, ir_load, busy, halted, fault,
                     s.pc, s.add_b, s.mem_rd, s.ir_load, s.busy, s.halted, s.fault);
         end
      end
      if ((mem_rd === 1'b1 && !prev_rd) || (halted === 1'b1 && !prev_halted)) begin
         n_vec++;
         if (ev_q.size() == 0) begin
            n_err++;
            $display("FAIL event: unexpected rd=%b hlt=%b pc=%h flt=%b", mem_rd, halted, pc, fault);
         end else begin
            e = ev_q.pop_front();
            if (e.halt !== halted || e.pc !== pc || e.fault !== fault) begin
               n_err++;
               $display("FAIL event: got halt=%b pc=%h fault=%b, want halt=%b pc=%h fault=%b",
                        halted, pc, fault, e.halt, e.pc, e.fault);
            end
         end
      end
      if (ir_load === 1'b1) begin
         n_vec++;
         if (prev_irl || !prev_rd) begin
            n_err++;
            $display("FAIL ir_load_pulse: got prev_irl=%b prev_rd=%b, want prev_irl=0 prev_rd=1",
                     prev_irl, prev_rd);
         end
      end
      prev_rd     = (mem_rd === 1'b1);
      prev_halted = (halted === 1'b1);
      prev_irl    = (ir_load === 1'b1);
      if (done) begin
         n_vec++;
         if (ev_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_events: got %0d left, want 0", ev_q.size());
         end
         $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, want completion");
      $fatal(1);
   end

   initial begin
      // Reset state
      tick();
      expect_now("reset", 8'h00, 8'h00, 0, 0, 0, 0, 0);
      rst = 1'b0;
      tick();
      expect_now("idle_hold", 8'h00, 8'h00, 0, 0, 0, 0, 0);

      // 1: basic fetch with mem_ready on the second FETCH cycle, then increment
      expect_event(0, 8'h00, 0);
      start = 1'b1; tick(); start = 1'b0;
      expect_now("t1_fetch1", 8'h00, 8'h00, 1, 0, 1, 0, 0);
      tick();
      expect_now("t1_fetch2", 8'h00, 8'h00, 1, 0, 1, 0, 0);
      mem_ready = 1'b1; tick(); mem_ready = 1'b0;
      expect_now("t1_latch", 8'h00, 8'h00, 0, 1, 1, 0, 0);
      tick();
      expect_now("t1_exec", 8'h00, 8'h00, 0, 0, 1, 0, 0);
      expect_event(0, 8'h01, 0);
      exec_done = 1'b1; tick(); exec_done = 1'b0;
      expect_now("t1_update", 8'h00, 8'h01, 0, 0, 1, 0, 0);
      tick();
      expect_now("t1_refetch", 8'h01, 8'h00, 1, 0, 1, 0, 0);

      // 2: skip and increment wrap-around
      fetch_ok(); exec_op(1, 8'hFE, 0, 0, 0, 8'hFE);
      fetch_ok(); exec_op(0, 8'h00, 1, 1, 0, 8'h00);
      expect_now("t2_fe_skip", 8'h00, 8'h00, 1, 0, 1, 0, 0);
      fetch_ok(); exec_op(1, 8'hFF, 0, 0, 0, 8'hFF);
      fetch_ok(); exec_op(0, 8'h00, 1, 1, 0, 8'h01);
      expect_now("t2_ff_skip", 8'h01, 8'h00, 1, 0, 1, 0, 0);
      fetch_ok(); exec_op(1, 8'hFF, 0, 0, 0, 8'hFF);
      fetch_ok(); exec_op(0, 8'h00, 1, 0, 0, 8'h00);
      expect_now("t2_ff_inc", 8'h00, 8'h00, 1, 0, 1, 0, 0);

      // 3: jump has priority over skip and bypasses the adder
      fetch_ok();
      expect_event(0, 8'h3C, 0);
      exec_done = 1'b1; jump = 1'b1; jump_addr = 8'h3C; skip_z = 1'b1; zero_flag = 1'b1;
      tick();
      exec_done = 1'b0; jump = 1'b0; jump_addr = 8'h00; skip_z = 1'b0; zero_flag = 1'b0;
      expect_now("t3_jump", 8'h3C, 8'h00, 1, 0, 1, 0, 0);

      // 4: halt after increment, start ignored, rst exits
      fetch_ok(); exec_op(1, 8'h10, 0, 0, 0, 8'h10);
      fetch_ok();
      expect_event(1, 8'h11, 0);
      exec_done = 1'b1; halt_req = 1'b1; tick(); exec_done = 1'b0; halt_req = 1'b0;
      expect_now("t4_update", 8'h10, 8'h01, 0, 0, 1, 0, 0);
      tick();
      expect_now("t4_halt", 8'h11, 8'h00, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         start = 1'b1; tick(); start = 1'b0; tick();
      end
      expect_now("t4_start_ignored", 8'h11, 8'h00, 0, 0, 0, 1, 0);
      rst = 1'b1; tick(); rst = 1'b0;
      expect_now("t4_reset", 8'h00, 8'h00, 0, 0, 0, 0, 0);

      // 5: fetch timeout after 15 cycles, then ready on the 15th cycle wins
      expect_event(0, 8'h00, 0);
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      expect_now("t5_cnt14", 8'h00, 8'h00, 1, 0, 1, 0, 0);
      expect_event(1, 8'h00, 1);
      tick();
      expect_now("t5_fault", 8'h00, 8'h00, 0, 0, 0, 1, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      expect_now("t5_fault_clr", 8'h00, 8'h00, 0, 0, 0, 0, 0);
      expect_event(0, 8'h00, 0);
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      mem_ready = 1'b1; tick(); mem_ready = 1'b0;
      expect_now("t5_late_ready", 8'h00, 8'h00, 0, 1, 1, 0, 0);
      tick();

      // 6: rst in EXEC and FETCH; exec_done in IDLE ignored
      exec_op(1, 8'h55, 0, 0, 0, 8'h55);
      fetch_ok();
      expect_now("t6_exec", 8'h55, 8'h00, 0, 0, 1, 0, 0);
      rst = 1'b1; exec_done = 1'b1; jump = 1'b1; jump_addr = 8'h77;
      tick();
      rst = 1'b0; exec_done = 1'b0; jump = 1'b0; jump_addr = 8'h00;
      expect_now("t6_rst_exec", 8'h00, 8'h00, 0, 0, 0, 0, 0);
      expect_event(0, 8'h00, 0);
      start = 1'b1; tick(); start = 1'b0;
      rst = 1'b1; mem_ready = 1'b1; tick(); rst = 1'b0; mem_ready = 1'b0;
      expect_now("t6_rst_fetch", 8'h00, 8'h00, 0, 0, 0, 0, 0);
      exec_done = 1'b1; jump = 1'b1; jump_addr = 8'h77; tick();
      jump = 1'b0; skip_z = 1'b1; zero_flag = 1'b1; tick();
      exec_done = 1'b0; skip_z = 1'b0; zero_flag = 1'b0; tick();
      expect_now("t6_idle_exec_done", 8'h00, 8'h00, 0, 0, 0, 0, 0);
      tick();
      done = 1'b1;
   end

endmodule
